// File: rtl/seg7_decoder.sv
// Seven-segment pattern decoder with a stability filter: a pattern must be seen
// STABLE_CYCLES consecutive samples before it is accepted and decoded to hex.
module seg7_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    output logic [3:0] digit_out,
    output logic       digit_valid,
    output logic       digit_strobe,
    output logic       blank,
    output logic       err_pulse,
    output logic [7:0] err_count
);

    localparam logic [7:0] STABLE_W = 8'(STABLE_CYCLES);

    typedef enum logic {SETTLE, LOCKED} state_t;

    state_t     state;
    logic [6:0] smp;
    logic [6:0] cand;
    logic [6:0] last_acc;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic       acc;
    logic [4:0] dec;

    // Returns {legal, hex}; 00 and unlisted codes come back with legal=0.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h3F: decode = 5'h10;
            7'h06: decode = 5'h11;
            7'h5B: decode = 5'h12;
            7'h4F: decode = 5'h13;
            7'h66: decode = 5'h14;
            7'h6D: decode = 5'h15;
            7'h7D: decode = 5'h16;
            7'h07: decode = 5'h17;
            7'h7F: decode = 5'h18;
            7'h6F: decode = 5'h19;
            7'h77: decode = 5'h1A;
            7'h7C: decode = 5'h1B;
            7'h39: decode = 5'h1C;
            7'h5E: decode = 5'h1D;
            7'h79: decode = 5'h1E;
            7'h71: decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    // Acceptance fires on the edge where the count would reach STABLE_CYCLES,
    // so STABLE_CYCLES=1 accepts a new sample on the very edge it is compared.
    always_comb begin
        cnt_nxt = cnt;
        if (smp != cand)
            cnt_nxt = 8'd1;
        else if (state == SETTLE)
            cnt_nxt = cnt + 8'd1;
        acc = ((state == SETTLE) || (smp != cand)) && (cnt_nxt == STABLE_W);
        dec = decode(smp);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state        <= SETTLE;
            smp          <= 7'h00;
            cand         <= 7'h00;
            last_acc     <= 7'h00;
            cnt          <= 8'd0;
            digit_out    <= 4'h0;
            digit_valid  <= 1'b0;
            digit_strobe <= 1'b0;
            blank        <= 1'b1;
            err_pulse    <= 1'b0;
            err_count    <= 8'd0;
        end else begin
            smp          <= ACTIVE_LOW ? ~seg_in : seg_in;
            cand         <= smp;
            cnt          <= cnt_nxt;
            digit_strobe <= 1'b0;
            err_pulse    <= 1'b0;
            if (acc)
                state <= LOCKED;
            else if (smp != cand)
                state <= SETTLE;
            // Re-accepting the pattern already shown is a recovered glitch: no effect.
            if (acc && (smp != last_acc)) begin
                last_acc <= smp;
                if (smp == 7'h00) begin
                    blank       <= 1'b1;
                    digit_valid <= 1'b0;
                end else if (dec[4]) begin
                    digit_out    <= dec[3:0];
                    digit_valid  <= 1'b1;
                    blank        <= 1'b0;
                    digit_strobe <= 1'b1;
                end else begin
                    digit_valid <= 1'b0;
                    blank       <= 1'b0;
                    err_pulse   <= 1'b1;
                    if (err_count != 8'hFF)
                        err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule
